// File: rtl/sequenceur_addition_multioctet.sv
// Multi-byte add/subtract sequencer: one 8-bit adder reused over NBYTES cycles,
// LSB byte first, with the inter-byte carry held in a register.
module sequenceur_addition_multioctet #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [8*NBYTES-1:0]   a_in,
  input  logic [8*NBYTES-1:0]   b_in,
  input  logic                  rin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   s_out,
  output logic                  rout,
  output logic                  ovf
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic            busy_d, done_d, rout_d, ovf_d;
  logic [W-1:0]    s_d;

  logic [7:0]      a_byte_c, b_byte_c;
  logic [8:0]      sum_c;
  logic            last_c;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_out   <= '0;
      rout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      busy    <= busy_d;
      done    <= done_d;
      s_out   <= s_d;
      rout    <= rout_d;
      ovf     <= ovf_d;
    end
  end

  // Shared byte adder and next-state logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    busy_d   = busy;
    done_d   = 1'b0;
    s_d      = s_out;
    rout_d   = rout;
    ovf_d    = ovf;

    a_byte_c = a_q[{idx_q, 3'b000} +: 8];
    b_byte_c = b_q[{idx_q, 3'b000} +: 8];
    sum_c    = 9'(a_byte_c) + 9'(b_byte_c) + 9'(carry_q);
    last_c   = (idx_q == IW'(NBYTES - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = op_sub ? ~b_in : b_in;
          carry_d = op_sub ? 1'b1 : rin;
          idx_d   = '0;
          busy_d  = 1'b1;
          s_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[{idx_q, 3'b000} +: 8] = sum_c[7:0];
        carry_d = sum_c[8];
        if (last_c) begin
          rout_d  = sum_c[8];
          // b_q already holds the inverted operand for subtraction
          ovf_d   = (a_byte_c[7] == b_byte_c[7]) && (sum_c[7] != a_byte_c[7]);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sequenceur_addition_multioctet.sv
// Bench for sequenceur_addition_multioctet (NBYTES=4): directed corner cases plus
// randomized runs compared against a plain-arithmetic reference.
module tb_sequenceur_addition_multioctet;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst, start, op_sub, rin;
  logic [W-1:0]  a_in, b_in;
  logic          busy, done, rout, ovf;
  logic [W-1:0]  s_out;

  int n_cmp = 0;
  int n_err = 0;

  sequenceur_addition_multioctet #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
    .a_in(a_in), .b_in(b_in), .rin(rin),
    .busy(busy), .done(done), .s_out(s_out), .rout(rout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, rout, s} from whole-word arithmetic
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic r, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : r);
    ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Launch one operation; returns with outputs sampled just after the done edge
  task automatic do_run(input logic [W-1:0] a, input logic [W-1:0] b, input logic r,
                        input logic sub, input string tag);
    logic [W+1:0] e;
    int n, bcnt;
    e = ref_op(a, b, r, sub);
    @(negedge clk);
    a_in = a; b_in = b; rin = r; op_sub = sub; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_s_clr"}, 64'(s_out), 64'd0);
    bcnt = int'(busy);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      a_in = $urandom; b_in = $urandom; rin = 1'($urandom); op_sub = 1'($urandom);
      tick();
      n++;
      bcnt += int'(busy);
    end
    chk({tag, "_lat"}, 64'(n), 64'(NB));
    chk({tag, "_busy"}, 64'(bcnt), 64'(NB));
    chk({tag, "_s"}, 64'(s_out), 64'(e[W-1:0]));
    chk({tag, "_rout"}, 64'(rout), 64'(e[W]));
    chk({tag, "_ovf"}, 64'(ovf), 64'(e[W+1]));
  endtask

  task automatic after_done(input string tag, input logic [W-1:0] s_exp);
    tick();
    chk({tag, "_done1cyc"}, 64'(done), 64'd0);
    chk({tag, "_hold"}, 64'(s_out), 64'(s_exp));
  endtask

  initial begin
    logic [W+1:0] e;
    logic [W-1:0] a, b;
    int n;
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; rin = 1'b0; a_in = '0; b_in = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_s", 64'(s_out), 64'd0);
    chk("rst_rout_ovf", 64'({rout, ovf}), 64'd0);
    @(negedge clk); rst = 1'b0;

    do_run(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "t1");
    chk("t1_const", 64'({ovf, rout, s_out}), 64'({2'b00, 32'h0000_0100}));
    after_done("t1", 32'h0000_0100);

    do_run(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "t2");
    chk("t2_const", 64'({ovf, rout, s_out}), 64'({2'b01, 32'h0000_0000}));

    do_run(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "t3a");
    chk("t3a_const", 64'({ovf, rout, s_out}), 64'({2'b10, 32'h8000_0000}));
    do_run(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, "t3b");
    chk("t3b_const", 64'({ovf, rout, s_out}), 64'({2'b11, 32'h7FFF_FFFF}));

    do_run(32'd5, 32'd7, 1'b1, 1'b1, "t4a");
    chk("t4a_const", 64'({ovf, rout, s_out}), 64'({2'b00, 32'hFFFF_FFFE}));
    do_run(32'd7, 32'd5, 1'b0, 1'b1, "t4b");
    chk("t4b_const", 64'({ovf, rout, s_out}), 64'({2'b01, 32'h0000_0002}));

    // Start pulse mid-run is ignored; start held in done cycle launches a new run
    e = ref_op(32'h1234_5678, 32'h0101_0101, 1'b1, 1'b0);
    @(negedge clk);
    a_in = 32'h1234_5678; b_in = 32'h0101_0101; rin = 1'b1; op_sub = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    a_in = 32'hDEAD_BEEF; b_in = 32'hCAFE_F00D; op_sub = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    n = 2;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
    chk("t5_lat", 64'(n), 64'(NB));
    chk("t5_first", 64'({ovf, rout, s_out}), 64'(e));
    a = 32'h0F0F_F0F0; b = 32'h1111_2222;
    e = ref_op(a, b, 1'b0, 1'b1);
    a_in = a; b_in = b; rin = 1'b0; op_sub = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("t5_b2b_busy", 64'(busy), 64'd1);
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
    chk("t5_b2b_lat", 64'(n), 64'(NB));
    chk("t5_b2b_res", 64'({ovf, rout, s_out}), 64'(e));

    // Reset during the second RUN cycle aborts the run
    do_run(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0, "t6pre");
    @(negedge clk);
    a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF; rin = 1'b1; op_sub = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_s", 64'(s_out), 64'd0);
    chk("t6_rout_ovf", 64'({rout, ovf}), 64'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin tick(); n += int'(done); end
    chk("t6_nodone", 64'(n), 64'd0);
    do_run(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, "t6post");

    for (int i = 0; i < 40; i++) begin
      do_run($urandom, $urandom, 1'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
